// File: rtl/icache_refill_unit.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_unit
// Description : ICache miss handler. Takes one line miss and issues a
//               line-aligned burst read. It collects the returned beats into
//               a full line, then writes line, tag and index into a
//               round-robin selected way of the tag/data arrays.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_unit #(
  parameter int PLEN        = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int BUS_WIDTH   = 64,
  parameter int SET_ASSOC   = 4,
  parameter int INDEX_WIDTH = 6,
  // derived widths, exposed only so the port list can use them
  parameter int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8),
  parameter int TAG_WIDTH    = PLEN - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   miss_valid_i,
  output logic                   miss_ready_o,
  input  logic [PLEN-1:0]        miss_paddr_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [PLEN-1:0]        mem_req_addr_o,
  output logic [7:0]             mem_req_len_o,
  input  logic                   mem_rsp_valid_i,
  output logic                   mem_rsp_ready_o,
  input  logic [BUS_WIDTH-1:0]   mem_rsp_data_i,
  input  logic                   mem_rsp_last_i,
  output logic                   refill_we_o,
  output logic [SET_ASSOC-1:0]   refill_way_o,
  output logic [INDEX_WIDTH-1:0] refill_index_o,
  output logic [TAG_WIDTH-1:0]   refill_tag_o,
  output logic [LINE_WIDTH-1:0]  refill_line_o,
  output logic                   busy_o
);

  localparam int BEATS     = LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT   = CNT_WIDTH'(BEATS - 1);
  localparam logic [PLEN-1:0]      OFFSET_MASK = PLEN'((64'd1 << OFFSET_WIDTH) - 64'd1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]            state;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [PLEN-1:0]       line_addr;
  logic [LINE_WIDTH-1:0] line_buf;
  logic [SET_ASSOC-1:0]  rr_way;

  logic accept;
  logic req_fire;
  logic beat_fire;
  logic beat_is_last;
  logic write_fire;
  logic unused_last;

  // The beat counter alone decides the end of a burst; the last flag is
  // deliberately ignored.
  assign unused_last = mem_rsp_last_i;

  assign miss_ready_o    = (state == S_IDLE) && !flush_i;
  assign accept          = miss_valid_i && miss_ready_o;
  assign mem_req_valid_o = (state == S_REQ);
  assign req_fire        = mem_req_valid_o && mem_req_ready_i;
  assign mem_rsp_ready_o = (state == S_RESP) || (state == S_DRAIN);
  assign beat_fire       = mem_rsp_valid_i && mem_rsp_ready_o;
  assign beat_is_last    = (beat_cnt == LAST_BEAT);
  assign write_fire      = (state == S_WRITE) && !flush_i;

  assign mem_req_addr_o = line_addr;
  assign mem_req_len_o  = 8'(BEATS - 1);
  assign refill_we_o    = write_fire;
  assign refill_way_o   = rr_way;
  assign refill_index_o = line_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign refill_tag_o   = line_addr[PLEN-1 -: TAG_WIDTH];
  assign refill_line_o  = line_buf;
  assign busy_o         = (state != S_IDLE);

  // Refill sequencing. A flush wins over normal progress, except that an
  // already-issued burst must still be drained.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state <= S_REQ;
        S_REQ: begin
          if (req_fire)     state <= flush_i ? S_DRAIN : S_RESP;
          else if (flush_i) state <= S_IDLE;
        end
        S_RESP: begin
          if (beat_fire && beat_is_last) state <= flush_i ? S_IDLE : S_WRITE;
          else if (flush_i)              state <= S_DRAIN;
        end
        S_DRAIN: if (beat_fire && beat_is_last) state <= S_IDLE;
        S_WRITE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat counter. It is cleared when the request is accepted and counts every
  // consumed beat, whether the beat is stored or discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt <= '0;
    end else if (req_fire) begin
      beat_cnt <= '0;
    end else if (beat_fire) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    end
  end

  // Capture the line-aligned miss address on accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_addr <= '0;
    end else if (accept) begin
      line_addr <= miss_paddr_i & ~OFFSET_MASK;
    end
  end

  // One slice register per beat position. Beats seen while draining are
  // not stored.
  for (genvar k = 0; k < BEATS; k++) begin : g_beat
    localparam logic [CNT_WIDTH-1:0] BEAT_ID = CNT_WIDTH'(k);
    // Store beat k into its slice of the line.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        line_buf[k*BUS_WIDTH +: BUS_WIDTH] <= '0;
      end else if (beat_fire && (state == S_RESP) && (beat_cnt == BEAT_ID)) begin
        line_buf[k*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data_i;
      end
    end
  end

  // Round-robin victim way. It advances only on a real array write.
  if (SET_ASSOC == 1) begin : g_rr_single
    assign rr_way = 1'b1;
  end else begin : g_rr_multi
    // Rotate the one-hot way left after each completed write.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rr_way <= SET_ASSOC'(1);
      end else if (write_fire) begin
        rr_way <= {rr_way[SET_ASSOC-2:0], rr_way[SET_ASSOC-1]};
      end
    end
  end

endmodule
`default_nettype wire
